toggle_stim_gen: RTL and testbench

//  Synthesizable stimulus source for the small combinational/latch-inference DUTs (4 single-bit inputs).

---
 rtl/toggle_stim_pkg.sv | 20 ++
 rtl/toggle_stim_gen_if.sv | 25 ++
 rtl/toggle_chan.sv | 46 ++++
 rtl/toggle_stim_gen.sv | 94 +++++++++
 tb/tb_toggle_stim_gen.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/toggle_stim_pkg.sv
// rtl/toggle_stim_pkg.sv - shared widths, defaults and FSM encoding for toggle_stim_gen
package toggle_stim_pkg;

    localparam int unsigned NUM_CH      = 4;
    localparam int unsigned CNT_W       = 12;
    localparam int unsigned RUN_W       = 12;
    localparam int unsigned DEF_RUN_LEN = 3000;

    localparam int unsigned DEF_PERIOD0 = 317;
    localparam int unsigned DEF_PERIOD1 = 37;
    localparam int unsigned DEF_PERIOD2 = 157;
    localparam int unsigned DEF_PERIOD3 = 67;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/toggle_stim_gen_if.sv
// rtl/toggle_stim_gen_if.sv - control, config and stimulus bundle of toggle_stim_gen
interface toggle_stim_gen_if;
    import toggle_stim_pkg::*;

    logic              start;
    logic              abort;
    logic              cfg_we;
    logic [1:0]        cfg_sel;
    logic [CNT_W-1:0]  cfg_period;
    logic [NUM_CH-1:0] stim;
    logic              busy;
    logic              done;
    logic [RUN_W-1:0]  cycle_cnt;

    modport master (
        output start, abort, cfg_we, cfg_sel, cfg_period,
        input  stim, busy, done, cycle_cnt
    );

    modport slave (
        input  start, abort, cfg_we, cfg_sel, cfg_period,
        output stim, busy, done, cycle_cnt
    );

endinterface

// File: rtl/toggle_chan.sv
// rtl/toggle_chan.sv - one square-wave channel: period register, half-period counter, stim flop
module toggle_chan #(
    parameter int unsigned CNT_W = 12,
    parameter int unsigned DEF_P = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             run,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_period,
    output logic             stim
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            period <= CNT_W'(DEF_P);
            cnt    <= '0;
            stim   <= 1'b0;
        end else begin
            if (cfg_we)
                period <= cfg_period;
            if (clr) begin
                cnt  <= '0;
                stim <= 1'b0;
            end else if (run) begin
                // Period 0 parks the channel low; the counter never leaves 0..period-1
                if (period == '0) begin
                    cnt  <= '0;
                    stim <= 1'b0;
                end else if (cnt == period - ONE) begin
                    cnt  <= '0;
                    stim <= ~stim;
                end else begin
                    cnt  <= cnt + ONE;
                end
            end
        end
    end

endmodule

// File: rtl/toggle_stim_gen.sv
// rtl/toggle_stim_gen.sv - bounded-run four-channel square-wave stimulus source
module toggle_stim_gen
    import toggle_stim_pkg::*;
#(
    parameter int unsigned RUN_LEN = DEF_RUN_LEN,
    parameter int unsigned DEF_P0  = DEF_PERIOD0,
    parameter int unsigned DEF_P1  = DEF_PERIOD1,
    parameter int unsigned DEF_P2  = DEF_PERIOD2,
    parameter int unsigned DEF_P3  = DEF_PERIOD3
) (
    input  logic               clk,
    input  logic               reset,
    toggle_stim_gen_if.slave   bus
);

    localparam int unsigned DEF_TBL [4] = '{DEF_P0, DEF_P1, DEF_P2, DEF_P3};
    localparam logic [RUN_W-1:0] LAST_CNT  = RUN_W'(RUN_LEN - 1);
    localparam logic [RUN_W-1:0] FINAL_CNT = RUN_W'(RUN_LEN);

    state_t            state;
    state_t            state_nxt;
    logic              chan_clr;
    logic              chan_run;
    logic              cfg_ok;
    logic [NUM_CH-1:0] chan_we;
    logic [RUN_W-1:0]  cycle_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        chan_clr  = 1'b0;
        chan_run  = 1'b0;
        cfg_ok    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                cfg_ok = 1'b1;
                if (bus.start && !bus.abort) begin
                    state_nxt = ST_RUN;
                    chan_clr  = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_nxt = ST_IDLE;
                    chan_clr  = 1'b1;
                end else begin
                    chan_run = 1'b1;
                    if (cycle_cnt == LAST_CNT)
                        state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        chan_we = '0;
        for (int i = 0; i < NUM_CH; i++)
            chan_we[i] = bus.cfg_we && cfg_ok && (bus.cfg_sel == i[1:0]);
    end

    always_ff @(posedge clk) begin
        if (reset || chan_clr)
            cycle_cnt <= '0;
        else if (chan_run && cycle_cnt != FINAL_CNT)
            cycle_cnt <= cycle_cnt + RUN_W'(1);
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_chan
        toggle_chan #(
            .CNT_W (CNT_W),
            .DEF_P (DEF_TBL[n])
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .clr        (chan_clr),
            .run        (chan_run),
            .cfg_we     (chan_we[n]),
            .cfg_period (bus.cfg_period),
            .stim       (bus.stim[n])
        );
    end

    assign bus.busy      = (state == ST_RUN);
    assign bus.done      = (state == ST_DONE);
    assign bus.cycle_cnt = cycle_cnt;

endmodule

// File: tb/tb_toggle_stim_gen.sv
// tb/tb_toggle_stim_gen.sv - table, directed and random checks of toggle_stim_gen
module tb_toggle_stim_gen;

    localparam int RUN_LEN = 3000;

    logic clk;
    logic reset;
    toggle_stim_gen_if bus ();

    toggle_stim_gen u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    bit       m_run;
    bit       m_done;
    int       m_k;
    logic [3:0] m_stim;
    int       m_per [4];

    typedef struct {
        string      name;
        bit         rst;
        int         cfg_ch;
        int         cfg_val;
        bit         st;
        int         wait_n;
        logic [3:0] e_stim;
        bit         e_busy;
        bit         e_done;
        int         e_cnt;
    } row_t;

    row_t tbl [9];

    function automatic logic [3:0] ref_stim(int k);
        logic [3:0] r;
        r = '0;
        for (int n = 0; n < 4; n++)
            if (m_per[n] != 0)
                r[n] = ((k / m_per[n]) % 2) == 1;
        return r;
    endfunction

    task automatic model_edge(bit rst, bit st, bit ab, bit we, int sel, int per);
        if (rst) begin
            m_per  = '{317, 37, 157, 67};
            m_run  = 0;
            m_done = 0;
            m_k    = 0;
            m_stim = '0;
        end else if (m_run) begin
            if (ab) begin
                m_run  = 0;
                m_k    = 0;
                m_stim = '0;
            end else begin
                m_k    = m_k + 1;
                m_stim = ref_stim(m_k);
                if (m_k == RUN_LEN) begin
                    m_run  = 0;
                    m_done = 1;
                end
            end
        end else begin
            if (we)
                m_per[sel] = per;
            if (st && !ab) begin
                m_run  = 1;
                m_done = 0;
                m_k    = 0;
                m_stim = '0;
            end
        end
    endtask

    task automatic cyc(bit rst, bit st, bit ab, bit we, int sel, int per);
        reset          = rst;
        bus.start      = st;
        bus.abort      = ab;
        bus.cfg_we     = we;
        bus.cfg_sel    = 2'(sel);
        bus.cfg_period = 12'(per);
        @(posedge clk);
        #1;
        model_edge(rst, st, ab, we, sel, per);
        vectors++;
        if (bus.stim !== m_stim || bus.busy !== m_run || bus.done !== m_done ||
            bus.cycle_cnt !== 12'(m_k)) begin
            miscompares++;
            $display("FAIL model k=%0d: got stim=%b busy=%b done=%b cnt=%0d, want stim=%b busy=%b done=%b cnt=%0d",
                     m_k, bus.stim, bus.busy, bus.done, bus.cycle_cnt, m_stim, m_run, m_done, m_k);
        end
    endtask

    task automatic idle(int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(string name, logic [3:0] es, bit eb, bit ed, int ec);
        vectors++;
        if (bus.stim !== es || bus.busy !== eb || bus.done !== ed || bus.cycle_cnt !== 12'(ec)) begin
            miscompares++;
            $display("FAIL %s: got stim=%b busy=%b done=%b cnt=%0d, want stim=%b busy=%b done=%b cnt=%0d",
                     name, bus.stim, bus.busy, bus.done, bus.cycle_cnt, es, eb, ed, ec);
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.cfg_we = 1'b0;
        bus.cfg_sel = 2'd0;
        bus.cfg_period = 12'd0;
        m_per = '{317, 37, 157, 67};
        m_run = 0;
        m_done = 0;
        m_k = 0;
        m_stim = '0;

        tbl[0] = '{"reset",          1'b1, -1, 0,  1'b0, 0,    4'b0000, 1'b0, 1'b0, 0};
        tbl[1] = '{"start",          1'b0, -1, 0,  1'b1, 0,    4'b0000, 1'b1, 1'b0, 0};
        tbl[2] = '{"k37",            1'b0, -1, 0,  1'b0, 37,   4'b0010, 1'b1, 1'b0, 37};
        tbl[3] = '{"k67",            1'b0, -1, 0,  1'b0, 30,   4'b1010, 1'b1, 1'b0, 67};
        tbl[4] = '{"k3000",          1'b0, -1, 0,  1'b0, 2933, 4'b0111, 1'b0, 1'b1, 3000};
        tbl[5] = '{"frozen",         1'b0, -1, 0,  1'b0, 5,    4'b0111, 1'b0, 1'b1, 3000};
        tbl[6] = '{"done_cfg_start", 1'b0, 3,  10, 1'b1, 0,    4'b0000, 1'b1, 1'b0, 0};
        tbl[7] = '{"ch3_k10",        1'b0, -1, 0,  1'b0, 10,   4'b1000, 1'b1, 1'b0, 10};
        tbl[8] = '{"ch3_k20",        1'b0, -1, 0,  1'b0, 10,   4'b0000, 1'b1, 1'b0, 20};

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].rst || tbl[i].cfg_ch >= 0 || tbl[i].st)
                cyc(tbl[i].rst, tbl[i].st, 0, tbl[i].cfg_ch >= 0,
                    (tbl[i].cfg_ch >= 0) ? tbl[i].cfg_ch : 0, tbl[i].cfg_val);
            idle(tbl[i].wait_n);
            chk(tbl[i].name, tbl[i].e_stim, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_cnt);
        end

        // period 1 and period 0 channels, then abort at k=100
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 1, 2, 0);
        cyc(0, 1, 0, 0, 0, 0);
        idle(1);
        chk("p1_k1", 4'b0001, 1, 0, 1);
        idle(1);
        chk("p1_k2", 4'b0000, 1, 0, 2);
        idle(98);
        cyc(0, 0, 1, 0, 0, 0);
        chk("abort", 4'b0000, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        idle(1);
        chk("restart_k1", 4'b0001, 1, 0, 1);

        // start+abort together in IDLE, then a config write dropped during RUN
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        chk("start_abort_idle", 4'b0000, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        idle(5);
        cyc(0, 0, 0, 1, 1, 5);
        idle(31);
        chk("cfg_in_run_dropped", 4'b0010, 1, 0, 37);

        // reset mid-run restores default periods
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 5);
        cyc(0, 1, 0, 0, 0, 0);
        idle(500);
        cyc(1, 0, 0, 0, 0, 0);
        chk("reset_mid_run", 4'b0000, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        idle(36);
        chk("defaults_k36", 4'b0000, 1, 0, 36);
        idle(1);
        chk("defaults_k37", 4'b0010, 1, 0, 37);

        repeat (4000) begin
            int r;
            r = $urandom_range(0, 999);
            cyc(r < 2, ($urandom % 40) == 0, ($urandom % 150) == 0, ($urandom % 10) == 0,
                $urandom_range(0, 3), $urandom_range(0, 24));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
